k423_if_ibuf: RTL and testbench

K423_IF_IBUF -- requirements
Module: k423_if_ibuf

---
 rtl/k423_if_ibuf.sv | 118 +++++++++++
 tb/tb_k423_if_ibuf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/k423_if_ibuf.sv
// Instruction buffer between fetch and decode: a circular FIFO of fetched words, PCs and fault flags.
// Optional same-cycle fetch-to-decode bypass when empty: define K423_IBUF_BYPASS_EN.
`ifndef CORE_INST_W
`define CORE_INST_W 32
`endif
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif

module k423_if_ibuf #(
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      fetch_vld_i,
    output logic                      fetch_rdy_o,
    input  logic [`CORE_INST_W-1:0]   fetch_inst_i,
    input  logic [`CORE_XLEN-1:0]     fetch_pc_i,
    input  logic                      fetch_fault_i,
    output logic                      if_vld_o,
    input  logic                      id_rdy_i,
    output logic [`CORE_INST_W-1:0]   if_inst_o,
    output logic [`CORE_XLEN-1:0]     if_pc_o,
    output logic                      if_fault_o,
    output logic [$clog2(DEPTH):0]    ibuf_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [`CORE_INST_W-1:0] r_inst [DEPTH];
    logic [`CORE_XLEN-1:0]   r_pc   [DEPTH];
    logic [DEPTH-1:0]        r_fault;
    logic [PW-1:0]           r_rd_ptr;
    logic [PW-1:0]           r_wr_ptr;
    logic [CW-1:0]           r_count;

    logic w_empty;
    logic w_full;
    logic w_byp;
    logic w_byp_take;
    logic w_vld;
    logic w_enq;
    logic w_deq;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

`ifdef K423_IBUF_BYPASS_EN
    // Reset gates the bypass so the output drops the moment reset asserts.
    assign w_byp = w_empty & fetch_vld_i & ~flush_i & ~rst_i;
`else
    assign w_byp = 1'b0;
`endif

    assign w_byp_take  = w_byp & id_rdy_i;
    assign w_vld       = (~w_empty & ~flush_i) | w_byp;
    assign fetch_rdy_o = ~w_full | (id_rdy_i & w_vld);
    // A bypassed word consumed by decode never occupies storage.
    assign w_enq       = fetch_vld_i & fetch_rdy_o & ~flush_i & ~w_byp_take;
    assign w_deq       = ~w_empty & id_rdy_i & ~flush_i;
    assign ibuf_cnt_o  = r_count;

    always_comb begin
        if_vld_o   = w_vld;
        if_inst_o  = '0;
        if_pc_o    = '0;
        if_fault_o = 1'b0;
        if (w_byp) begin
            if_inst_o  = fetch_inst_i;
            if_pc_o    = fetch_pc_i;
            if_fault_o = fetch_fault_i;
        end else if (w_vld) begin
            if_inst_o  = r_inst[r_rd_ptr];
            if_pc_o    = r_pc[r_rd_ptr];
            if_fault_o = r_fault[r_rd_ptr];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is never observable while empty, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_inst[r_wr_ptr]  <= fetch_inst_i;
            r_pc[r_wr_ptr]    <= fetch_pc_i;
            r_fault[r_wr_ptr] <= fetch_fault_i;
        end
    end

endmodule

// File: tb/tb_k423_if_ibuf.sv
// Scoreboard bench for k423_if_ibuf: stimulus model pushes accepted fetches, negedge monitor pops and compares.
`ifndef CORE_INST_W
`define CORE_INST_W 32
`endif
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif

module tb_k423_if_ibuf;
    localparam int DEPTH = 4;
    localparam int IW    = `CORE_INST_W;
    localparam int XW    = `CORE_XLEN;
`ifdef K423_IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   fvld;
    logic                   frdy;
    logic [IW-1:0]          finst;
    logic [XW-1:0]          fpc;
    logic                   ffault;
    logic                   ivld;
    logic                   idrdy;
    logic [IW-1:0]          iinst;
    logic [XW-1:0]          ipc;
    logic                   ifault;
    logic [$clog2(DEPTH):0] cnt;

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [XW-1:0] pc;
        logic          fault;
    } ent_t;

    ent_t sb[$];
    int   mcnt   = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    k423_if_ibuf #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .fetch_vld_i  (fvld),
        .fetch_rdy_o  (frdy),
        .fetch_inst_i (finst),
        .fetch_pc_i   (fpc),
        .fetch_fault_i(ffault),
        .if_vld_o     (ivld),
        .id_rdy_i     (idrdy),
        .if_inst_o    (iinst),
        .if_pc_o      (ipc),
        .if_fault_o   (ifault),
        .ibuf_cnt_o   (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: advances on each clock edge from the inputs driven during the cycle.
    bit p_byp, p_ev, p_er, p_enq, p_deq;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt = 0;
            sb.delete();
        end else begin
            p_byp = BYP && mcnt == 0 && fvld && !flush;
            p_ev  = (mcnt != 0 && !flush) || p_byp;
            p_er  = mcnt < DEPTH || (idrdy && p_ev);
            p_enq = fvld && p_er && !flush && !(p_byp && idrdy);
            p_deq = mcnt != 0 && idrdy && !flush;
            if (flush) begin
                mcnt = 0;
                sb.delete();
            end else begin
                if (p_enq) sb.push_back('{inst: finst, pc: fpc, fault: ffault});
                mcnt = mcnt + int'(p_enq) - int'(p_deq);
            end
        end
    end

    bit   m_byp, m_ev, m_er;
    ent_t m_exp;
    always @(negedge clk) begin
        if (!rst) begin
            m_byp = BYP && mcnt == 0 && fvld && !flush;
            m_ev  = (mcnt != 0 && !flush) || m_byp;
            m_er  = mcnt < DEPTH || (idrdy && m_ev);
            chk("mon_cnt", 64'(cnt), 64'(mcnt));
            chk("mon_fetch_rdy", 64'(frdy), 64'(m_er));
            chk("mon_if_vld", 64'(ivld), 64'(m_ev));
            if (m_ev) begin
                if (m_byp) begin
                    m_exp = '{inst: finst, pc: fpc, fault: ffault};
                end else if (sb.size() == 0) begin
                    m_exp = '0;
                    n_cmp++;
                    n_err++;
                    $display("FAIL mon_sb_empty: got empty scoreboard expected an entry at %0t", $time);
                end else begin
                    m_exp = sb[0];
                end
                chk("mon_inst", 64'(iinst), 64'(m_exp.inst));
                chk("mon_pc", 64'(ipc), 64'(m_exp.pc));
                chk("mon_fault", 64'(ifault), 64'(m_exp.fault));
                if (!m_byp && idrdy && sb.size() > 0) void'(sb.pop_front());
            end else begin
                chk("mon_zero_data", 64'((|iinst) | (|ipc) | ifault), 64'(0));
            end
        end
    end

    task automatic drv(input bit v, input logic [IW-1:0] inst, input logic [XW-1:0] pc,
                       input bit f, input bit r, input bit fl);
        fvld   = v;
        finst  = inst;
        fpc    = pc;
        ffault = f;
        idrdy  = r;
        flush  = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drv(0, '0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 64'(ivld), 64'(0));
        chk("rst_rdy", 64'(frdy), 64'(1));
        chk("rst_cnt", 64'(cnt), 64'(0));
        chk("rst_data", 64'((|iinst) | (|ipc) | ifault), 64'(0));
        rst = 1'b0;

        // single word through with decode ready
        drv(1, 32'h0000_0013, 32'h8000_0000, 0, 1, 0);
        tick();
`ifndef K423_IBUF_BYPASS_EN
        chk("r030_cnt1", 64'(cnt), 64'(1));
        chk("r030_vld", 64'(ivld), 64'(1));
        chk("r030_inst", 64'(iinst), 64'h13);
        chk("r030_pc", 64'(ipc), 64'h8000_0000);
`endif
        drv(0, '0, '0, 0, 1, 0);
        tick();
        chk("r030_cnt0", 64'(cnt), 64'(0));

        // fill with decode stalled, then hold a fifth fetch
        for (int i = 0; i < 4; i++) begin
            drv(1, 32'h100 + 32'(i), 32'(i * 4), 0, 0, 0);
            tick();
        end
        chk("r031_cnt4", 64'(cnt), 64'(4));
        drv(1, 32'h104, 32'h10, 0, 0, 0);
        #1 chk("r031_rdy0", 64'(frdy), 64'(0));
        tick();
        tick();
        chk("r031_hold_cnt", 64'(cnt), 64'(4));
        chk("r031_hold_pc", 64'(ipc), 64'h0);
        // full with simultaneous enqueue and dequeue
        drv(1, 32'h104, 32'h10, 0, 1, 0);
        #1 chk("r032_rdy1", 64'(frdy), 64'(1));
        tick();
        chk("r032_cnt4", 64'(cnt), 64'(4));
        chk("r032_head_pc", 64'(ipc), 64'h4);
        drv(0, '0, '0, 0, 1, 0);
        repeat (4) tick();
        chk("r031_drained", 64'(cnt), 64'(0));

        // fault flag confined to its own entry
        drv(1, 32'h200, 32'h40, 0, 1, 0); tick();
        drv(1, 32'h201, 32'h44, 1, 1, 0); tick();
        drv(1, 32'h202, 32'h48, 0, 1, 0); tick();
        drv(0, '0, '0, 0, 1, 0);
        repeat (3) tick();

        // flush with three queued and a same-cycle enqueue
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'h300 + 32'(i), 32'h20 + 32'(i * 4), 0, 0, 0);
            tick();
        end
        chk("r033_cnt3", 64'(cnt), 64'(3));
        drv(1, 32'h303, 32'h2C, 0, 0, 1);
        #1 chk("r033_vld_in_flush", 64'(ivld), 64'(0));
        tick();
        chk("r033_cnt0", 64'(cnt), 64'(0));
        chk("r033_vld0", 64'(ivld), 64'(0));
        drv(1, 32'h400, 32'h100, 0, 0, 0);
        tick();
        chk("r033_head_pc", 64'(ipc), 64'h100);
        drv(0, '0, '0, 0, 1, 0);
        repeat (2) tick();

        // reset asserted mid-cycle with entries queued
        drv(1, 32'h500, 32'h50, 0, 0, 0); tick();
        drv(1, 32'h501, 32'h54, 0, 0, 0); tick();
        drv(1, 32'h502, 32'h58, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("r027_vld0", 64'(ivld), 64'(0));
        chk("r027_cnt0", 64'(cnt), 64'(0));
        drv(1, 32'h600, 32'h80, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("r027_cnt1", 64'(cnt), 64'(1));
        chk("r027_head_pc", 64'(ipc), 64'h80);
        drv(0, '0, '0, 0, 1, 0);
        tick();
        chk("r027_cnt_after", 64'(cnt), 64'(0));

`ifdef K423_IBUF_BYPASS_EN
        drv(1, 32'h700, 32'h200, 0, 1, 0);
        #1;
        chk("r035_byp_vld", 64'(ivld), 64'(1));
        chk("r035_byp_pc", 64'(ipc), 64'h200);
        tick();
        chk("r035_byp_cnt0", 64'(cnt), 64'(0));
        drv(1, 32'h701, 32'h204, 0, 1, 0);
        #1 rst = 1'b1;
        #1 chk("r035_rst_vld0", 64'(ivld), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        drv(0, '0, '0, 0, 1, 0);
        tick();
`endif

        drv(0, '0, '0, 0, 1, 0);
        repeat (2) tick();
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
